// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the iteration-counter width helper.
package mdu_pkg;

  localparam int MDU_N = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_t;

  // The counter holds values N..0, so it needs clog2(N+1) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int MDU_CNT_W = cnt_width(MDU_N);

endpackage

// File: rtl/mdu_divider.sv
// Restoring-division step datapath: one quotient bit per step, operating on
// unsigned magnitudes. Sign fix-up and divide-by-zero handling live in the top.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0] dvs_q;
  logic [N:0]   rem_sh;
  logic         fits;
  logic [N-1:0] trial;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    rem_sh = {remainder, quotient[N-1]};
    fits   = (rem_sh >= {1'b0, dvs_q});
    // When the subtract fits, the true difference is below the divisor and
    // therefore fits in N bits, so modular N-bit arithmetic is exact.
    trial  = rem_sh[N-1:0] - dvs_q;
  end

  // Load operands on start, then retire one quotient bit per step.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvs_q     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs_q     <= divisor;
    end else if (step) begin
      quotient  <= {quotient[N-2:0], fits};
      remainder <= fits ? trial : rem_sh[N-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO
// registers. Start/busy/done handshake, N iterations per operation.
// Optional build macro MDU_EARLY_TERM_EN: multiplies finish as soon as the
// remaining multiplier bits are all zero (results unchanged, latency shorter).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  input  logic         hi_write,
  input  logic         lo_write,
  input  logic [N-1:0] write_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = cnt_width(N);

  state_t         state;
  logic [1:0]     op_q;
  logic           sign_a, sign_b, b_zero;
  logic [N-1:0]   a_raw;
  logic [CW-1:0]  cnt;

  // Shift-add multiply datapath: accumulator, left-shifting multiplicand,
  // right-shifting multiplier.
  logic [2*N-1:0] acc, mcand;
  logic [N-1:0]   mplier;

  logic           is_signed;
  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] acc_nxt, prod;
  logic [N-1:0]   mplier_nxt;
  logic           run_last;
  logic [N-1:0]   div_quo, div_rem, quo_s, rem_s;

  mdu_divider #(.N(N)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (state == IDLE && start),
    .step      (state == RUN && op_q[1]),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Operand magnitudes, next multiply step, end-of-run detect and sign fix-up.
  always_comb begin
    is_signed  = (op == OP_MULT) || (op == OP_DIV);
    mag_a      = (is_signed && operand_a[N-1]) ? -operand_a : operand_a;
    mag_b      = (is_signed && operand_b[N-1]) ? -operand_b : operand_b;
    acc_nxt    = mplier[0] ? acc + mcand : acc;
    mplier_nxt = mplier >> 1;
    run_last   = (cnt == CW'(1));
`ifdef MDU_EARLY_TERM_EN
    // Once the unconsumed multiplier bits are zero, no further adds can occur.
    if (!op_q[1] && (mplier_nxt == '0)) run_last = 1'b1;
`endif
    prod  = ((op_q == OP_MULT) && (sign_a ^ sign_b)) ? -acc : acc;
    quo_s = ((op_q == OP_DIV) && (sign_a ^ sign_b)) ? -div_quo : div_quo;
    rem_s = ((op_q == OP_DIV) && sign_a) ? -div_rem : div_rem;
  end

  // Control FSM with registered handshake outputs and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= OP_MULT;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_raw       <= '0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= is_signed && operand_a[N-1];
            sign_b <= is_signed && operand_b[N-1];
            b_zero <= (operand_b == '0);
            a_raw  <= operand_a;
            cnt    <= CW'(N);
            acc    <= '0;
            mcand  <= {{N{1'b0}}, mag_a};
            mplier <= mag_b;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            if (hi_write) hi <= write_data;
            if (lo_write) lo <= write_data;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          cnt    <= cnt - CW'(1);
          if (run_last) state <= FINISH;
        end
        FINISH: begin
          if (!op_q[1]) begin
            {hi, lo} <= prod;
          end else if (b_zero) begin
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, write_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.N(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .write_data  (write_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {div_by_zero, hi, lo} from the architectural definition.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      OP_DIV: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
    logic [31:0] m;
    int          iters;
    if (o == OP_MULT || o == OP_MULTU) begin
      m = (o == OP_MULT && b[31]) ? -b : b;
      iters = 1;
      for (int i = 0; i < 32; i++) if (m[i]) iters = i + 1;
      return iters + 1;
    end
`else
    if (o == OP_MULT && b == 32'd0) return 33;
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit lo_w, input string tag);
    logic [64:0] exp;
    int          n;
    bit          got_done, busy_ok;
    exp = model(o, a, b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    if (lo_w) begin lo_write = 1'b1; write_data = 32'h1357_9BDF; end
    @(posedge clk); #1;
    start = 1'b0; lo_write = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
    check({tag, "_busy_start"}, busy, 1'b1);
    n = 0; got_done = 0; busy_ok = 1;
    while (!got_done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; hi_write = 1'b1; write_data = 32'hDEAD_BEEF;
      end else if (disturb && n == 6) begin
        start = 1'b0; hi_write = 1'b0;
      end
      if (done) got_done = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    check({tag, "_latency"}, n, exp_latency(o, b));
    check({tag, "_busy_held"}, busy_ok, 1'b1);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    check({tag, "_dbz"}, div_by_zero, exp[64]);
    check({tag, "_busy_done"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_dbz_pulse"}, div_by_zero, 1'b0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    op = OP_MULT; operand_a = '0; operand_b = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;

    // MTHI / MTLO while idle
    @(negedge clk); hi_write = 1'b1; write_data = 32'hA5A5_A5A5;
    @(posedge clk); #1; hi_write = 1'b0;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, 32'd0);
    @(negedge clk); lo_write = 1'b1; write_data = 32'h1234_5678;
    @(posedge clk); #1; lo_write = 1'b0;
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi", hi, 32'hA5A5_A5A5);
    @(negedge clk); hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h0F0F_0F0F;
    @(posedge clk); #1; hi_write = 1'b0; lo_write = 1'b0;
    check("mtboth_hi", hi, 32'h0F0F_0F0F);
    check("mtboth_lo", lo, 32'h0F0F_0F0F);

    // Directed operations
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         0, 0, "mult_neg");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, "div_neg");
    run_op(OP_DIVU,  32'd100,       32'd7,         0, 0, "divu");
    run_op(OP_DIVU,  32'h0000_1234, 32'd0,         0, 0, "divu_zero");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(OP_DIV,   32'hFFFF_FF00, 32'd0,         0, 0, "div_zero_neg");
    run_op(OP_MULTU, 32'd5,         32'd1,         0, 0, "multu_small");
    run_op(OP_DIVU,  32'd1000000,   32'd37,        1, 0, "disturb");
    run_op(OP_MULTU, 32'd9,         32'd11,        0, 1, "start_lo_w");

    // Reset in the middle of a run
    @(negedge clk);
    op = OP_MULTU; operand_a = $urandom; operand_b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", done, 1'b0);
    run_op(OP_MULTU, 32'd6, 32'd7, 0, 0, "after_rst");

    // Randomized operations with biased operands
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 255);
        2: rb = -32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
